// File: rtl/vscpu_irq_ctrl.sv
// vscpu_irq_ctrl: prioritised, maskable edge/level interrupt controller for VerySimpleCPU.
// Register window: PEND (W1C), MASK, CLAIM (read-only), EOI (write-only).
module vscpu_irq_ctrl #(
    parameter int                 SIZE      = 14,
    parameter int                 NUM_IRQ   = 8,
    parameter logic [SIZE-1:0]    BASE_ADDR = 14'h3FF0,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = {NUM_IRQ{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               wrEn,
    input  logic [SIZE-1:0]    addr_toRAM,
    input  logic [31:0]        data_toRAM,
    output logic [31:0]        rd_data,
    output logic               rd_hit,
    output logic               interrupt,
    output logic [4:0]         cur_id,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, FIRE, SERVICE} state_t;

    state_t             state, state_next;
    logic [NUM_IRQ-1:0] irq_q, pending, mask, active, set, clr, eoi_clr;
    logic [4:0]         win_id;
    logic [31:0]        rd_val;
    logic               in_win, wr_pend, wr_mask, eoi;
    logic [1:0]         off;
    logic               unused_data;

    assign in_win      = addr_toRAM[SIZE-1:2] == BASE_ADDR[SIZE-1:2];
    assign off         = addr_toRAM[1:0];
    assign wr_pend     = wrEn && in_win && off == 2'd0;
    assign wr_mask     = wrEn && in_win && off == 2'd1;
    assign eoi         = wrEn && in_win && off == 2'd3;
    assign set         = (EDGE_MASK & irq_in & ~irq_q) | (~EDGE_MASK & irq_in);
    assign clr         = (wr_pend ? data_toRAM[NUM_IRQ-1:0] : '0) | eoi_clr;
    assign active      = pending & mask;
    assign unused_data = ^data_toRAM;

    // Out-of-range EOI indices match no channel and so clear nothing.
    always_comb begin
        eoi_clr = '0;
        win_id  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            eoi_clr[i] = eoi && data_toRAM[4:0] == 5'(i);
            if (active[i]) win_id = 5'(i);
        end
    end

    assign rd_val = off == 2'd0 ? 32'(pending) :
                    off == 2'd1 ? 32'(mask) :
                    off == 2'd2 ? {|active, 26'd0, win_id} : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            irq_q   <= '0;
            pending <= '0;
            mask    <= '0;
            rd_data <= '0;
            rd_hit  <= 1'b0;
            cur_id  <= '0;
        end else begin
            state   <= state_next;
            irq_q   <= irq_in;
            pending <= (pending & ~clr) | set;
            if (wr_mask) mask <= data_toRAM[NUM_IRQ-1:0];
            rd_data <= in_win ? rd_val : 32'd0;
            rd_hit  <= in_win;
            if (state == IDLE && |active) cur_id <= win_id;
        end
    end

    always_comb
        state_next = state == IDLE ? (|active ? FIRE : IDLE) :
                     state == FIRE ? SERVICE :
                     (eoi ? IDLE : SERVICE);

    always_comb begin
        interrupt = state == FIRE;
        busy      = state != IDLE;
    end
endmodule

// File: tb/tb_vscpu_irq_ctrl.sv
// tb_vscpu_irq_ctrl: table-driven per-cycle vectors plus a hand-written reset-abort sequence.
module tb_vscpu_irq_ctrl;
    localparam logic [13:0] PEND = 14'h3FF0, MSK = 14'h3FF1, CLM = 14'h3FF2, EOI = 14'h3FF3, OUT = 14'h3FF4;

    logic        clk = 0, rst = 1, wr_en = 0, interrupt, rd_hit, busy;
    logic [7:0]  irq_in = 0;
    logic [13:0] addr = 0;
    logic [31:0] wdata = 0, rd_data;
    logic [4:0]  cur_id;
    int checks = 0, errors = 0;

    typedef struct {
        logic        wr;
        logic [13:0] addr;
        logic [31:0] data;
        logic [7:0]  irq;
        logic [31:0] rd;
        logic        hit, intr, bsy;
        logic [4:0]  id;
    } vec_t;
    vec_t v[$];

    vscpu_irq_ctrl #(.SIZE(14), .NUM_IRQ(8), .BASE_ADDR(14'h3FF0), .EDGE_MASK(8'hFE)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .wrEn(wr_en), .addr_toRAM(addr),
        .data_toRAM(wdata), .rd_data(rd_data), .rd_hit(rd_hit), .interrupt(interrupt),
        .cur_id(cur_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic [13:0] a, input logic [31:0] d, input logic [7:0] irq);
        wr_en = w; addr = a; wdata = d; irq_in = irq;
        @(posedge clk); #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] rd, input logic hit, input logic intr,
                           input logic bsy, input logic [4:0] id);
        chk({tag, " rd_data"}, rd_data, rd);
        chk({tag, " rd_hit"}, 32'(rd_hit), 32'(hit));
        chk({tag, " interrupt"}, 32'(interrupt), 32'(intr));
        chk({tag, " busy"}, 32'(busy), 32'(bsy));
        chk({tag, " cur_id"}, 32'(cur_id), 32'(id));
    endtask

    initial begin
        // wr addr data irq | rd hit int busy id
        v.push_back('{1, MSK,  32'hFF, 8'h00, 32'h0,        1, 0, 0, 0});
        v.push_back('{0, MSK,  32'h0,  8'h08, 32'hFF,       1, 0, 0, 0});
        v.push_back('{0, CLM,  32'h0,  8'h00, 32'h80000003, 1, 1, 1, 3});
        v.push_back('{0, PEND, 32'h0,  8'h00, 32'h08,       1, 0, 1, 3});
        v.push_back('{1, EOI,  32'd3,  8'h00, 32'h0,        1, 0, 0, 3});
        v.push_back('{0, PEND, 32'h0,  8'h00, 32'h0,        1, 0, 0, 3});
        v.push_back('{0, 14'h0,32'h0,  8'h22, 32'h0,        0, 0, 0, 3});
        v.push_back('{0, CLM,  32'h0,  8'h00, 32'h80000001, 1, 1, 1, 1});
        v.push_back('{0, PEND, 32'h0,  8'h00, 32'h22,       1, 0, 1, 1});
        v.push_back('{1, EOI,  32'd1,  8'h00, 32'h0,        1, 0, 0, 1});
        v.push_back('{0, CLM,  32'h0,  8'h00, 32'h80000005, 1, 1, 1, 5});
        v.push_back('{1, EOI,  32'd5,  8'h00, 32'h0,        1, 0, 1, 5});
        v.push_back('{1, EOI,  32'd5,  8'h00, 32'h0,        1, 0, 0, 5});
        v.push_back('{1, MSK,  32'h00, 8'h00, 32'hFF,       1, 0, 0, 5});
        v.push_back('{0, 14'h0,32'h0,  8'h04, 32'h0,        0, 0, 0, 5});
        v.push_back('{0, PEND, 32'h0,  8'h00, 32'h04,       1, 0, 0, 5});
        v.push_back('{0, CLM,  32'h0,  8'h00, 32'h0,        1, 0, 0, 5});
        v.push_back('{1, MSK,  32'h04, 8'h00, 32'h0,        1, 0, 0, 5});
        v.push_back('{0, CLM,  32'h0,  8'h00, 32'h80000002, 1, 1, 1, 2});
        v.push_back('{1, EOI,  32'd2,  8'h00, 32'h0,        1, 0, 1, 2});
        v.push_back('{0, PEND, 32'h0,  8'h00, 32'h0,        1, 0, 1, 2});
        v.push_back('{0, 14'h0,32'h0,  8'h40, 32'h0,        0, 0, 1, 2});
        v.push_back('{1, EOI,  32'd31, 8'h00, 32'h0,        1, 0, 0, 2});
        v.push_back('{0, PEND, 32'h0,  8'h00, 32'h40,       1, 0, 0, 2});
        v.push_back('{1, PEND, 32'h40, 8'h00, 32'h40,       1, 0, 0, 2});
        v.push_back('{1, OUT,  32'hFF, 8'h00, 32'h0,        0, 0, 0, 2});
        v.push_back('{0, PEND, 32'h0,  8'h00, 32'h0,        1, 0, 0, 2});
        v.push_back('{0, MSK,  32'h0,  8'h00, 32'h04,       1, 0, 0, 2});
        v.push_back('{1, MSK,  32'h01, 8'h01, 32'h04,       1, 0, 0, 2});
        v.push_back('{1, PEND, 32'h01, 8'h01, 32'h01,       1, 1, 1, 0});
        v.push_back('{0, PEND, 32'h0,  8'h01, 32'h01,       1, 0, 1, 0});
        v.push_back('{1, PEND, 32'h01, 8'h01, 32'h01,       1, 0, 1, 0});
        v.push_back('{0, PEND, 32'h0,  8'h00, 32'h01,       1, 0, 1, 0});
        v.push_back('{1, PEND, 32'h01, 8'h00, 32'h01,       1, 0, 1, 0});
        v.push_back('{0, PEND, 32'h0,  8'h00, 32'h0,        1, 0, 1, 0});
        v.push_back('{1, EOI,  32'd0,  8'h00, 32'h0,        1, 0, 0, 0});

        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk_all("reset", 32'h0, 0, 0, 0, 0);

        foreach (v[i])
            begin
                step(v[i].wr, v[i].addr, v[i].data, v[i].irq);
                chk_all($sformatf("vec%0d", i), v[i].rd, v[i].hit, v[i].intr, v[i].bsy, v[i].id);
            end

        // Reset asserted mid-service with pending=0x0A aborts everything.
        step(1, MSK, 32'h0A, 8'h00);
        step(0, 14'h0, 32'h0, 8'h0A);
        step(0, 14'h0, 32'h0, 8'h00);
        chk("rs fire interrupt", 32'(interrupt), 32'h1);
        chk("rs fire cur_id", 32'(cur_id), 32'd1);
        step(0, PEND, 32'h0, 8'h00);
        chk("rs service busy", 32'(busy), 32'h1);
        chk("rs pend before", rd_data, 32'h0A);
        #2 rst = 1;
        #1 chk_all("rs async", 32'h0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 14'h0, 32'h0, 8'h00);
            chk_all($sformatf("rs idle%0d", i), 32'h0, 0, 0, 0, 0);
        end
        step(0, PEND, 32'h0, 8'h00);
        chk("rs pend after", rd_data, 32'h0);
        step(0, MSK, 32'h0, 8'h00);
        chk("rs mask after", rd_data, 32'h0);
        chk("rs no pulse", 32'(interrupt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
